prod_sched: RTL and testbench

//  Single-clock scheduler that shares the one write port of the CDC buffer wrapper

---
 rtl/prod_sched_pkg.sv | 31 +++
 rtl/prod_sched_if.sv | 34 +++
 rtl/prod_sched_resume_cnt.sv | 27 ++
 rtl/prod_sched.sv | 112 +++++++++++
 tb/tb_prod_sched.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/prod_sched_pkg.sv
// Shared encodings for the producer scheduler: FSM states, display source codes, default word width.
package prod_sched_pkg;

  localparam int DW_DEF = 16;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_COMM_F = 3'd1,
    S_WAIT_F = 3'd2,
    S_COMM_T = 3'd3,
    S_WAIT_T = 3'd4,
    S_DRAIN  = 3'd5
  } state_t;

  localparam logic [1:0] SRC_NONE = 2'd0;
  localparam logic [1:0] SRC_FIB  = 2'd1;
  localparam logic [1:0] SRC_TMR  = 2'd2;

  function automatic logic [5:0] state_led(input state_t s);
    return 6'b000001 << s;
  endfunction

  function automatic logic [1:0] state_src(input state_t s);
    case (s)
      S_COMM_F, S_WAIT_F: return SRC_FIB;
      S_COMM_T, S_WAIT_T: return SRC_TMR;
      default:            return SRC_NONE;
    endcase
  endfunction

endpackage

// File: rtl/prod_sched_if.sv
// Scheduler port bundle: control pulses, producer words, buffer status, write port and status.
// slave is the scheduler's view; master is the surrounding logic's view.
interface prod_sched_if import prod_sched_pkg::*; #(parameter int DW = DW_DEF);
  logic          start_f;
  logic          start_t;
  logic          stop;
  logic          f_valid;
  logic [DW-1:0] f_data;
  logic          t_valid;
  logic [DW-1:0] t_data;
  logic          buf_full;
  logic          buf_empty;
  logic          rd_valid;
  logic          f_en;
  logic          t_en;
  logic          wr_en;
  logic [DW-1:0] wr_data;
  logic [1:0]    src_sel;
  logic [5:0]    led;
  logic [15:0]   word_cnt;
  logic          wd_err;

  modport slave (
    input  start_f, start_t, stop, f_valid, f_data, t_valid, t_data,
           buf_full, buf_empty, rd_valid,
    output f_en, t_en, wr_en, wr_data, src_sel, led, word_cnt, wd_err
  );

  modport master (
    output start_f, start_t, stop, f_valid, f_data, t_valid, t_data,
           buf_full, buf_empty, rd_valid,
    input  f_en, t_en, wr_en, wr_data, src_sel, led, word_cnt, wd_err
  );
endinterface

// File: rtl/prod_sched_resume_cnt.sv
// Saturating run-length counter with clear; done flags the cycle that completes DLY counted cycles.
// Latency 0 on done (combinational on inc), clear has priority over counting.
module resume_cnt #(
  parameter int DLY = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic done
);
  localparam int CW = $clog2(DLY + 1);
  localparam logic [CW-1:0] LAST = CW'(DLY - 1);
  localparam logic [CW-1:0] TOP  = CW'(DLY);

  logic [CW-1:0] cnt;

  assign done = inc && (cnt >= LAST);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (inc && cnt != TOP) begin
      cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/prod_sched.sv
// Shares the buffer write port between Fibonacci and Timer producers; write path latency 1, enables drop on buf_full.
// Optional drain watchdog under PROD_SCHED_WATCHDOG_EN; otherwise DRAIN waits for empty and wd_err is 0.
module prod_sched import prod_sched_pkg::*; #(
  parameter int DW            = DW_DEF,
  parameter int RESUME_DLY    = 4,
  parameter int DRAIN_TIMEOUT = 1024
) (
  input  logic         clk,
  input  logic         rst,
  prod_sched_if.slave  io
);
  state_t        state;
  state_t        nxt;
  logic          rs_done;
  logic          wd_fire;
  logic          in_wait;
  logic          in_comm;
  logic          sel_wr;
  logic [DW-1:0] sel_data;
  logic          leave_idle;

  assign io.f_en    = (state == S_COMM_F) && !io.buf_full;
  assign io.t_en    = (state == S_COMM_T) && !io.buf_full;
  assign in_wait    = (state == S_WAIT_F) || (state == S_WAIT_T);
  assign in_comm    = (state == S_COMM_F) || (state == S_COMM_T);
  assign leave_idle = (state == S_IDLE) && (nxt != S_IDLE);

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:   if (io.start_f) nxt = S_COMM_F;
                else if (io.start_t) nxt = S_COMM_T;
      S_COMM_F: if (io.stop) nxt = S_DRAIN;
                else if (io.buf_full) nxt = S_WAIT_F;
      S_WAIT_F: if (io.stop) nxt = S_DRAIN;
                else if (rs_done) nxt = S_COMM_F;
      S_COMM_T: if (io.stop) nxt = S_DRAIN;
                else if (io.buf_full) nxt = S_WAIT_T;
      S_WAIT_T: if (io.stop) nxt = S_DRAIN;
                else if (rs_done) nxt = S_COMM_T;
      S_DRAIN:  if ((io.buf_empty && !io.rd_valid) || wd_fire) nxt = S_IDLE;
      default:  nxt = S_IDLE;
    endcase
  end

  // One counter serves both wait states; any state change restarts the run.
  resume_cnt #(.DLY(RESUME_DLY)) u_resume (
    .clk  (clk),
    .rst  (rst),
    .clr  (io.buf_full || (nxt != state)),
    .inc  (in_wait && !io.buf_full),
    .done (rs_done)
  );

  always_comb begin
    sel_wr   = 1'b0;
    sel_data = io.f_data;
    if (state == S_COMM_F) begin
      sel_wr = io.f_valid && io.f_en;
    end else if (state == S_COMM_T) begin
      sel_wr   = io.t_valid && io.t_en;
      sel_data = io.t_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      io.led      <= 6'b000001;
      io.src_sel  <= SRC_NONE;
      io.wr_en    <= 1'b0;
      io.wr_data  <= '0;
      io.word_cnt <= '0;
    end else begin
      state      <= nxt;
      io.led     <= state_led(nxt);
      io.src_sel <= state_src(nxt);
      io.wr_en   <= sel_wr;
      if (in_comm) io.wr_data <= sel_data;
      if (leave_idle) begin
        io.word_cnt <= '0;
      end else if (io.wr_en && io.word_cnt != 16'hFFFF) begin
        io.word_cnt <= io.word_cnt + 16'd1;
      end
    end
  end

`ifdef PROD_SCHED_WATCHDOG_EN
  localparam int DCW = $clog2(DRAIN_TIMEOUT + 1);
  logic [DCW-1:0] drain_cnt;
  logic           wd_err_q;

  assign wd_fire   = (state == S_DRAIN) && (drain_cnt == DCW'(DRAIN_TIMEOUT - 1));
  assign io.wd_err = wd_err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      drain_cnt <= '0;
      wd_err_q  <= 1'b0;
    end else begin
      if (state != S_DRAIN || nxt != S_DRAIN) drain_cnt <= '0;
      else drain_cnt <= drain_cnt + 1'b1;
      if (leave_idle) wd_err_q <= 1'b0;
      else if (wd_fire) wd_err_q <= 1'b1;
    end
  end
`else
  assign wd_fire   = 1'b0;
  // No watchdog: the timeout only appears in a constant-false term.
  assign io.wd_err = (DRAIN_TIMEOUT < 0);
`endif
endmodule

// File: tb/tb_prod_sched.sv
// Directed bench for prod_sched: session flow, back-pressure resume, priority, drain, watchdog, reset.
module tb_prod_sched;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  localparam logic [5:0] L_IDLE = 6'b000001, L_CF = 6'b000010, L_WF = 6'b000100,
                         L_CT = 6'b001000, L_WT = 6'b010000, L_DR = 6'b100000;

  always #5 clk = ~clk;

  prod_sched_if #(.DW(16)) bus ();

  prod_sched #(.DW(16), .RESUME_DLY(4), .DRAIN_TIMEOUT(8)) dut (
    .clk (clk),
    .rst (rst),
    .io  (bus.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1);
  end

  initial begin
    logic [15:0] fib [5];
    fib[0] = 16'd1; fib[1] = 16'd1; fib[2] = 16'd2; fib[3] = 16'd3; fib[4] = 16'd5;

    rst = 1'b1;
    bus.start_f = 0; bus.start_t = 0; bus.stop = 0;
    bus.f_valid = 0; bus.f_data = 0; bus.t_valid = 0; bus.t_data = 0;
    bus.buf_full = 0; bus.buf_empty = 0; bus.rd_valid = 0;
    step(); step();
    chk("rst_led", bus.led, L_IDLE);
    chk("rst_wr_en", bus.wr_en, 0);
    chk("rst_wr_data", bus.wr_data, 0);
    chk("rst_word_cnt", bus.word_cnt, 0);
    chk("rst_src_sel", bus.src_sel, 0);
    chk("rst_f_en", bus.f_en, 0);
    chk("rst_t_en", bus.t_en, 0);
    chk("rst_wd_err", bus.wd_err, 0);
    rst = 1'b0;
    step();
    chk("idle_hold", bus.led, L_IDLE);

    // 1: Fibonacci session
    bus.start_f = 1; step(); bus.start_f = 0;
    chk("t1_led", bus.led, L_CF);
    chk("t1_src", bus.src_sel, 1);
    #1 chk("t1_f_en", bus.f_en, 1);
    bus.f_valid = 1;
    for (int i = 0; i < 5; i++) begin
      bus.f_data = fib[i];
      step();
      chk("t1_wr_en", bus.wr_en, 1);
      chk("t1_wr_data", bus.wr_data, fib[i]);
    end
    bus.f_valid = 0;
    step();
    chk("t1_wr_en_off", bus.wr_en, 0);
    chk("t1_word_cnt", bus.word_cnt, 5);
    chk("t1_led_end", bus.led, L_CF);

    // 2: back-pressure and resume delay
    bus.buf_full = 1; bus.f_valid = 1; bus.f_data = 16'h0BAD;
    #1 chk("t2_f_en_gated", bus.f_en, 0);
    step(); bus.f_valid = 0;
    chk("t2_wait", bus.led, L_WF);
    chk("t2_src", bus.src_sel, 1);
    chk("t2_drop", bus.wr_en, 0);
    bus.buf_full = 0; step(); step(); step();
    chk("t2_after3", bus.led, L_WF);
    bus.buf_full = 1; step();
    chk("t2_refull", bus.led, L_WF);
    bus.buf_full = 0; step(); step(); step();
    chk("t2_after3b", bus.led, L_WF);
    step();
    chk("t2_resume", bus.led, L_CF);
    chk("t2_cnt_dropped", bus.word_cnt, 5);

    // stop with a valid word in the same cycle: word is still written
    bus.f_valid = 1; bus.f_data = 16'h00AA; bus.stop = 1;
    step(); bus.stop = 0; bus.f_valid = 0;
    chk("stop_led", bus.led, L_DR);
    chk("stop_src", bus.src_sel, 0);
    chk("stop_wr_en", bus.wr_en, 1);
    chk("stop_wr_data", bus.wr_data, 16'h00AA);
    bus.buf_empty = 1; step();
    chk("stop_idle", bus.led, L_IDLE);
    chk("stop_cnt_hold", bus.word_cnt, 6);

    // 3: simultaneous starts, Fibonacci wins
    bus.start_f = 1; bus.start_t = 1; step(); bus.start_f = 0; bus.start_t = 0;
    chk("t3_led", bus.led, L_CF);
    chk("t3_src", bus.src_sel, 1);
    chk("t3_cnt_clr", bus.word_cnt, 0);
    #1 chk("t3_t_en", bus.t_en, 0);
    bus.stop = 1; step(); bus.stop = 0;
    chk("t3_drain", bus.led, L_DR);
    step();
    chk("t3_idle", bus.led, L_IDLE);

    // 4: Timer session, drain waits for empty and no consumer word
    bus.buf_empty = 0;
    bus.start_t = 1; step(); bus.start_t = 0;
    chk("t4_led", bus.led, L_CT);
    chk("t4_src", bus.src_sel, 2);
    #1 chk("t4_t_en", bus.t_en, 1);
    bus.t_valid = 1; bus.t_data = 16'h1234; step();
    chk("t4_wr_en", bus.wr_en, 1);
    chk("t4_wr_data", bus.wr_data, 16'h1234);
    bus.stop = 1; step(); bus.stop = 0; bus.t_valid = 0;
    chk("t4_drain", bus.led, L_DR);
    #1 chk("t4_t_en_off", bus.t_en, 0);
    bus.buf_empty = 1; bus.rd_valid = 1; step();
    chk("t4_rd_hold1", bus.led, L_DR);
    step();
    chk("t4_rd_hold2", bus.led, L_DR);
    bus.rd_valid = 0; step();
    chk("t4_idle", bus.led, L_IDLE);
    chk("t4_word_cnt", bus.word_cnt, 2);

    // 5: drain with buffer never emptying
    bus.buf_empty = 0;
    bus.start_f = 1; step(); bus.start_f = 0;
    bus.stop = 1; step(); bus.stop = 0;
    chk("t5_drain", bus.led, L_DR);
`ifdef PROD_SCHED_WATCHDOG_EN
    repeat (7) step();
    chk("t5_drain7", bus.led, L_DR);
    chk("t5_wd_pre", bus.wd_err, 0);
    step();
    chk("t5_forced_idle", bus.led, L_IDLE);
    chk("t5_wd_err", bus.wd_err, 1);
    bus.start_f = 1; step(); bus.start_f = 0;
    chk("t5_wd_clr", bus.wd_err, 0);
    chk("t5_restart", bus.led, L_CF);
    bus.stop = 1; bus.buf_empty = 1; step(); bus.stop = 0;
    step();
`else
    repeat (20) step();
    chk("t5_drain_wait", bus.led, L_DR);
    chk("t5_wd_zero", bus.wd_err, 0);
    bus.buf_empty = 1; step();
`endif
    chk("t5_idle", bus.led, L_IDLE);

    // 6: reset in WAIT_T with valids high
    bus.buf_empty = 0;
    bus.start_t = 1; step(); bus.start_t = 0;
    bus.t_valid = 1; bus.t_data = 16'h0055; step();
    chk("t6_wr_en", bus.wr_en, 1);
    bus.f_valid = 1; bus.buf_full = 1; step();
    chk("t6_wait", bus.led, L_WT);
    chk("t6_cnt", bus.word_cnt, 1);
    bus.buf_full = 0;
    rst = 1; step();
    chk("t6_led", bus.led, L_IDLE);
    chk("t6_wr_en", bus.wr_en, 0);
    chk("t6_word_cnt", bus.word_cnt, 0);
    chk("t6_src", bus.src_sel, 0);
    chk("t6_wr_data", bus.wr_data, 0);
    #1 chk("t6_t_en", bus.t_en, 0);
    rst = 0; bus.t_valid = 0; bus.f_valid = 0;
    step();
    chk("t6_idle_after", bus.led, L_IDLE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
